// File: rtl/pulse_train_gen_if.sv
// Bundles the control and status lines of the pulse-train transmitter.
// master drives the request side; slave is the transmitter itself.
interface pulse_train_gen_if #(
  parameter int unsigned CntW = 8
) ();
  logic            nul;
  logic            start;
  logic [CntW-1:0] count_in;
  logic            signal_out;
  logic            busy;
  logic            done;
  logic [CntW-1:0] pulses_sent;

  modport master (
    output nul,
    output start,
    output count_in,
    input  signal_out,
    input  busy,
    input  done,
    input  pulses_sent
  );

  modport slave (
    input  nul,
    input  start,
    input  count_in,
    output signal_out,
    output busy,
    output done,
    output pulses_sent
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Falling-edge pulse-count link transmitter: emits N low-going pulses of fixed
// low/high width on a registered line, reporting busy, done and pulses issued.
module pulse_train_gen #(
  parameter int unsigned CntW       = 8,
  parameter int unsigned LowCycles  = 4,
  parameter int unsigned HighCycles = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pulse_train_gen_if.slave   bus_io
);

  localparam int unsigned MaxPhase = (LowCycles > HighCycles) ? LowCycles : HighCycles;
  localparam int unsigned TimerW   = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;
  localparam logic [TimerW-1:0] LowLast  = TimerW'(LowCycles - 1);
  localparam logic [TimerW-1:0] HighLast = TimerW'(HighCycles - 1);

  // Receiver runs a 3-FF synchroniser; shorter phases would be missed.
  if (LowCycles < 2 || HighCycles < 2) begin : gen_param_check
    $error("pulse_train_gen: LowCycles and HighCycles must both be >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CntW-1:0]   remaining_q, remaining_d;
  logic [CntW-1:0]   sent_q, sent_d;
  logic              signal_q, signal_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      signal_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      signal_q    <= signal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    signal_d    = signal_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (!bus_io.nul) begin
      // Abort wins over everything but reset; a coincident start is dropped.
      state_d     = StIdle;
      timer_d     = '0;
      remaining_d = '0;
      sent_d      = '0;
      signal_d    = 1'b1;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            sent_d  = '0;
            timer_d = '0;
            if (bus_io.count_in != '0) begin
              state_d     = StLow;
              remaining_d = bus_io.count_in;
              signal_d    = 1'b0;
              busy_d      = 1'b1;
              sent_d      = CntW'(1);
            end else begin
              done_d = 1'b1;
            end
          end
        end

        StLow: begin
          if (timer_q == LowLast) begin
            state_d  = StHigh;
            timer_d  = '0;
            signal_d = 1'b1;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end

        StHigh: begin
          if (timer_q == HighLast) begin
            timer_d = '0;
            if (remaining_q > CntW'(1)) begin
              state_d     = StLow;
              remaining_d = remaining_q - CntW'(1);
              signal_d    = 1'b0;
              sent_d      = sent_q + CntW'(1);
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end

        default: begin
          state_d  = StIdle;
          timer_d  = '0;
          signal_d = 1'b1;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign bus_io.signal_out  = signal_q;
  assign bus_io.busy        = busy_q;
  assign bus_io.done        = done_q;
  assign bus_io.pulses_sent = sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: each accepted train queues its expected
// edge count, busy length and final pulses_sent; a monitor checks them on done.
module tb_pulse_train_gen;

  typedef struct {
    int edges;
    int busy_cyc;
    int sent;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pulse_train_gen_if #(.CntW(8)) bus ();

  pulse_train_gen #(
    .CntW      (8),
    .LowCycles (4),
    .HighCycles(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   mon_edges = 0;
  int   mon_busy = 0;
  logic prev_sig = 1'b1;

  // Loopback receiver: 3-FF synchroniser and falling-edge counter.
  logic [2:0] rx_sync = 3'b111;
  int         rx_cnt = 0;
  logic       rx_clr = 1'b0;

  always @(posedge clk) begin
    rx_sync <= {rx_sync[1:0], bus.signal_out};
    if (rx_clr) rx_cnt <= 0;
    else if (rx_sync[2] && !rx_sync[1]) rx_cnt <= rx_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_edges = 0;
    mon_busy  = 0;
  endtask

  task automatic start_train(input int n, input bit expect_done);
    bus.start    = 1'b1;
    bus.count_in = 8'(n);
    if (expect_done) sb_q.push_back('{n, n * 8, n});
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.busy === 1'b0 && sb_q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL wait_idle: got busy=%0b pending=%0d required idle within %0d cycles",
             bus.busy, sb_q.size(), limit);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_sig === 1'b1 && bus.signal_out === 1'b0) mon_edges++;
      if (bus.busy === 1'b1) mon_busy++;
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 required no pending train");
        end else begin
          mon_e = sb_q.pop_front();
          check("edges", mon_edges, mon_e.edges);
          check("busy_cycles", mon_busy, mon_e.busy_cyc);
          check("pulses_sent_at_done", int'(bus.pulses_sent), mon_e.sent);
        end
        mon_edges = 0;
        mon_busy  = 0;
      end
    end
    prev_sig = bus.signal_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.nul      = 1'b1;
    bus.start    = 1'b0;
    bus.count_in = '0;
    rx_clr       = 1'b1;
    tick();
    tick();
    check("rst_signal_out", int'(bus.signal_out), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_pulses_sent", int'(bus.pulses_sent), 0);
    rst_n = 1'b1;
    mon_clear();
    tick();

    // Basic three-pulse train, first-cycle outputs checked directly.
    start_train(3, 1'b1);
    check("t1_first_signal", int'(bus.signal_out), 0);
    check("t1_first_busy", int'(bus.busy), 1);
    check("t1_first_sent", int'(bus.pulses_sent), 1);
    wait_idle(100);
    check("t1_final_signal", int'(bus.signal_out), 1);

    // Zero-length request: done only.
    start_train(0, 1'b1);
    check("t2_busy", int'(bus.busy), 0);
    check("t2_done", int'(bus.done), 1);
    check("t2_signal", int'(bus.signal_out), 1);
    wait_idle(10);

    // Full-range count, no wrap.
    start_train(255, 1'b1);
    wait_idle(2100);
    check("t3_sent", int'(bus.pulses_sent), 255);

    // Start while busy is ignored and count_in is not re-latched.
    start_train(5, 1'b1);
    repeat (18) tick();
    bus.start    = 1'b1;
    bus.count_in = 8'd9;
    tick();
    bus.start = 1'b0;
    wait_idle(100);
    check("t4_sent", int'(bus.pulses_sent), 5);

    // Abort during the third LOW phase.
    start_train(10, 1'b0);
    for (int i = 0; i < 100 && bus.pulses_sent != 8'd3; i++) tick();
    check("t5_in_third_low", int'(bus.signal_out), 0);
    bus.nul = 1'b0;
    tick();
    bus.nul = 1'b1;
    check("t5_abort_signal", int'(bus.signal_out), 1);
    check("t5_abort_busy", int'(bus.busy), 0);
    check("t5_abort_sent", int'(bus.pulses_sent), 0);
    check("t5_abort_done", int'(bus.done), 0);
    mon_clear();
    repeat (10) tick();
    check("t5_stays_idle", int'(bus.busy), 0);

    // Abort coincident with start drops the start.
    bus.nul      = 1'b0;
    bus.start    = 1'b1;
    bus.count_in = 8'd4;
    tick();
    bus.nul   = 1'b1;
    bus.start = 1'b0;
    check("t5_nul_start_busy", int'(bus.busy), 0);
    tick();
    check("t5_nul_start_dropped", int'(bus.busy), 0);
    check("t5_nul_start_signal", int'(bus.signal_out), 1);

    start_train(2, 1'b1);
    wait_idle(100);

    // Loopback: back-to-back 7 then 4, restarted in the done cycle.
    rx_clr = 1'b1;
    tick();
    rx_clr = 1'b0;
    start_train(7, 1'b1);
    sb_q.push_back('{4, 32, 4});
    begin
      int guard = 0;
      @(negedge clk);
      while (bus.done !== 1'b1 && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("t6_first_done_seen", int'(bus.done), 1);
      bus.start    = 1'b1;
      bus.count_in = 8'd4;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("t6_b2b_busy", int'(bus.busy), 1);
    end
    wait_idle(100);
    repeat (6) tick();
    check("t6_rx_count", rx_cnt, 11);

    // Reset mid-LOW.
    start_train(3, 1'b0);
    tick();
    check("t6_low_before_rst", int'(bus.signal_out), 0);
    rst_n = 1'b0;
    tick();
    check("t6_rst_signal", int'(bus.signal_out), 1);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_done", int'(bus.done), 0);
    check("t6_rst_sent", int'(bus.pulses_sent), 0);
    rst_n = 1'b1;
    mon_clear();
    repeat (10) tick();
    check("t6_after_rst_idle", int'(bus.busy), 0);

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
